// File: rtl/text_line_sequencer.sv
// Steps through a 16-entry text buffer, strobing one character per frame to a
// glyph renderer exactly when the video counters reach that character's cell.
module text_line_sequencer #(
  parameter logic [9:0] ORIGIN_X = 10'd16,
  parameter logic [9:0] ORIGIN_Y = 10'd32,
  parameter logic       LOOP     = 1'b0
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [5:0] wr_chr,
  input  logic [4:0] len,
  input  logic       start,
  input  logic       charDone,
  output logic [5:0] chr,
  output logic       drCh,
  output logic       busy,
  output logic       done
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CHR_W   = 6;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned CELL_SH = 3;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_STROBE    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_NEXT      = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [CHR_W-1:0]   chr_q, chr_d;
  logic               drch_q, drch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               char_done_prev_q, char_done_prev_d;
  logic               line_ok_q, line_ok_d;
  logic [CHR_W-1:0]   txt_q [DEPTH];
  logic [CHR_W-1:0]   txt_d [DEPTH];

  logic [LEN_W-1:0]   len_clamped;
  logic [COORD_W-1:0] target_x;
  logic               arm_hit;
  logic               char_rise;
  logic [LEN_W-1:0]   idx_inc;
  logic [CHR_W-1:0]   strobe_chr;

  // Text buffer: writes land on every edge regardless of FSM state.
  always_comb begin
    txt_d = txt_q;
    if (wr_en) txt_d[wr_addr] = wr_chr;
  end

  // Cell geometry, edge detect and write-through selection.
  always_comb begin
    len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    target_x    = ORIGIN_X + (COORD_W'(idx_q) << CELL_SH);
    arm_hit     = line_ok_q && (CounterY == ORIGIN_Y) &&
                  (CounterX == (target_x - COORD_W'(1)));
    char_rise   = charDone && !char_done_prev_q;
    idx_inc     = LEN_W'(idx_q) + LEN_W'(1);
    strobe_chr  = (wr_en && (wr_addr == idx_q)) ? wr_chr : txt_q[idx_q];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    count_d          = count_q;
    chr_d            = chr_q;
    drch_d           = 1'b0;
    busy_d           = busy_q;
    done_d           = 1'b0;
    char_done_prev_d = charDone;
    // A row other than the text row must pass before the next strobe,
    // which limits the renderer to one cell per frame.
    line_ok_d        = line_ok_q | (CounterY != ORIGIN_Y);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = len_clamped;
          if (len_clamped == LEN_W'(0)) begin
            done_d = 1'b1;
          end else begin
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (arm_hit) begin
          chr_d     = strobe_chr;
          drch_d    = 1'b1;
          line_ok_d = 1'b0;
          state_d   = S_STROBE;
        end
      end
      S_STROBE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (char_rise) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_inc < count_q) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ARM;
        end else if (LOOP) begin
          idx_d   = '0;
          state_d = S_ARM;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      count_q          <= '0;
      chr_q            <= '0;
      drch_q           <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      char_done_prev_q <= 1'b0;
      line_ok_q        <= 1'b1;
      for (int i = 0; i < DEPTH; i++) txt_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      count_q          <= count_d;
      chr_q            <= chr_d;
      drch_q           <= drch_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      char_done_prev_q <= char_done_prev_d;
      line_ok_q        <= line_ok_d;
      txt_q            <= txt_d;
    end
  end

  assign chr  = chr_q;
  assign drCh = drch_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_text_line_sequencer.sv
// Directed bench: a reduced video sweep (rows 30..33, X 0..159) drives two
// sequencers (LOOP=0 and LOOP=1) with a simple renderer model answering strobes.
module tb_text_line_sequencer;

  logic       pixclk = 1'b0;
  logic       reset;
  logic [9:0] CounterX, CounterY;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [5:0] wr_chr;
  logic [4:0] len;
  logic       start, start_l;
  logic       charDone, charDone_l;
  logic [5:0] chr, chr_l;
  logic       drCh, drCh_l, busy, busy_l, done, done_l;

  always #5 pixclk = ~pixclk;

  text_line_sequencer u_dut (
    .pixclk(pixclk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chr(wr_chr), .len(len),
    .start(start), .charDone(charDone),
    .chr(chr), .drCh(drCh), .busy(busy), .done(done)
  );

  text_line_sequencer #(.LOOP(1'b1)) u_dut_loop (
    .pixclk(pixclk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chr(wr_chr), .len(len),
    .start(start_l), .charDone(charDone_l),
    .chr(chr_l), .drCh(drCh_l), .busy(busy_l), .done(done_l)
  );

  int checks = 0;
  int failures = 0;
  int fr = 0;
  int n_st, n_hi, n_done, nl_st, nl_done;
  int rd_cnt, rdl_cnt;
  bit auto_r;
  bit prev_dr, prev_drl;
  logic [9:0] st_x[$];
  logic [9:0] st_y[$];
  logic [5:0] st_c[$];
  logic [9:0] stl_x[$];
  bit wt_en, wt_fire;
  int wt_fr;
  logic [9:0] wt_x;
  logic [3:0] wt_addr;
  logic [5:0] wt_chr;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (wt_en && CounterX == wt_x && CounterY == 10'd32 && fr > wt_fr) begin
      wr_en = 1'b1; wr_addr = wt_addr; wr_chr = wt_chr;
      wt_en = 1'b0; wt_fire = 1'b1;
    end
    @(posedge pixclk);
    #1;
    if (wt_fire) begin wr_en = 1'b0; wt_fire = 1'b0; end
    if (CounterX == 10'd159) begin
      CounterX = 10'd0;
      if (CounterY == 10'd33) begin CounterY = 10'd30; fr++; end
      else CounterY = CounterY + 10'd1;
    end else begin
      CounterX = CounterX + 10'd1;
    end
    if (drCh) begin
      n_hi++;
      if (!prev_dr) begin
        n_st++;
        st_x.push_back(CounterX); st_y.push_back(CounterY); st_c.push_back(chr);
        if (auto_r) rd_cnt = 8;
      end
    end
    prev_dr = drCh;
    if (done) n_done++;
    if (drCh_l && !prev_drl) begin
      nl_st++; stl_x.push_back(CounterX); rdl_cnt = 8;
    end
    prev_drl = drCh_l;
    if (done_l) nl_done++;
    if (auto_r) begin
      if (rd_cnt > 0) rd_cnt--;
      charDone = (rd_cnt > 0 && rd_cnt <= 3);
    end
    if (rdl_cnt > 0) rdl_cnt--;
    charDone_l = (rdl_cnt > 0 && rdl_cnt <= 3);
  endtask

  task automatic clr_mon();
    n_st = 0; n_hi = 0; n_done = 0; nl_st = 0; nl_done = 0;
    rd_cnt = 0; rdl_cnt = 0;
    st_x.delete(); st_y.delete(); st_c.delete(); stl_x.delete();
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_chr = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic sync_frame();
    int g = 0;
    while (!(CounterX == 10'd0 && CounterY == 10'd30) && g < 700) begin tick(); g++; end
    chk("sync_frame", int'(CounterX), 0);
  endtask

  task automatic run_frames(input int n);
    int tgt = fr + n;
    int g = 0;
    while (fr < tgt && g < 640 * n + 700) begin tick(); g++; end
    chk("run_frames_bound", fr, tgt);
  endtask

  task automatic wait_strobe();
    int g = 0;
    while (!drCh && g < 2000) begin tick(); g++; end
    chk("wait_strobe", int'(drCh), 1);
  endtask

  task automatic pulse_start(input logic [4:0] l);
    len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; CounterX = 10'd0; CounterY = 10'd30;
    wr_en = 1'b0; wr_addr = '0; wr_chr = '0; len = '0;
    start = 1'b0; start_l = 1'b0; charDone = 1'b0; charDone_l = 1'b0;
    auto_r = 1'b1; prev_dr = 1'b0; prev_drl = 1'b0;
    wt_en = 1'b0; wt_fire = 1'b0; wt_fr = 0; wt_x = '0; wt_addr = '0; wt_chr = '0;
    clr_mon();

    // Reset state
    tick(); tick();
    chk("rst_chr", int'(chr), 0);
    chk("rst_drCh", int'(drCh), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // len=0 start on the first edge after reset release
    reset = 1'b0; len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done_pulse", int'(done), 1);
    chk("len0_busy", int'(busy), 0);
    tick();
    chk("len0_done_one_cycle", int'(done), 0);
    run_frames(1);
    chk("len0_no_strobe", n_st, 0);
    chk("len0_busy_after", int'(busy), 0);

    // Basic three-character line
    wr(4'd0, 6'h1B); wr(4'd1, 6'h1C); wr(4'd2, 6'h1D);
    sync_frame(); clr_mon();
    pulse_start(5'd3);
    chk("basic_busy_up", int'(busy), 1);
    run_frames(4);
    chk("basic_strobes", n_st, 3);
    chk("basic_hi_cycles", n_hi, 3);
    if (n_st == 3) begin
      chk("basic_x0", int'(st_x[0]), 16); chk("basic_y0", int'(st_y[0]), 32);
      chk("basic_x1", int'(st_x[1]), 24); chk("basic_y1", int'(st_y[1]), 32);
      chk("basic_x2", int'(st_x[2]), 32); chk("basic_y2", int'(st_y[2]), 32);
      chk("basic_c0", int'(st_c[0]), 'h1B);
      chk("basic_c1", int'(st_c[1]), 'h1C);
      chk("basic_c2", int'(st_c[2]), 'h1D);
    end
    chk("basic_done_cnt", n_done, 1);
    chk("basic_busy_down", int'(busy), 0);

    // Restart ignored while busy; write-through on the strobe cycle of idx 1
    wr(4'd0, 6'h05); wr(4'd1, 6'h06); wr(4'd2, 6'h07);
    sync_frame(); clr_mon();
    wt_en = 1'b1; wt_fr = fr; wt_x = 10'd23; wt_addr = 4'd1; wt_chr = 6'h2A;
    pulse_start(5'd3);
    repeat (50) tick();
    pulse_start(5'd1);
    run_frames(4);
    chk("wt_strobes", n_st, 3);
    if (n_st == 3) begin
      chk("wt_c0", int'(st_c[0]), 'h05);
      chk("wt_c1", int'(st_c[1]), 'h2A);
      chk("wt_c2", int'(st_c[2]), 'h07);
      chk("wt_x2", int'(st_x[2]), 32);
    end
    chk("wt_done_cnt", n_done, 1);

    // len=20 clamps to 16
    for (int i = 0; i < 16; i++) wr(4'(i), 6'(i + 1));
    sync_frame(); clr_mon();
    pulse_start(5'd20);
    run_frames(18);
    chk("clamp_strobes", n_st, 16);
    chk("clamp_hi_cycles", n_hi, 16);
    if (n_st == 16) begin
      for (int i = 0; i < 16; i++) chk("clamp_x", int'(st_x[i]), 16 + 8 * i);
      chk("clamp_last_c", int'(st_c[15]), 'h10);
    end
    chk("clamp_done_cnt", n_done, 1);

    // LOOP=1 instance alternates indefinitely
    sync_frame(); clr_mon();
    len = 5'd2; start_l = 1'b1;
    tick();
    start_l = 1'b0;
    run_frames(6);
    chk("loop_strobes", nl_st, 6);
    if (nl_st == 6) begin
      for (int i = 0; i < 6; i++) chk("loop_x", int'(stl_x[i]), (i % 2 == 0) ? 16 : 24);
    end
    chk("loop_no_done", nl_done, 0);
    chk("loop_busy", int'(busy_l), 1);

    // Reset in the middle of a strobe
    sync_frame(); clr_mon();
    pulse_start(5'd3);
    wait_strobe();
    chk("mid_chr_before", int'(chr), 'h01);
    reset = 1'b1;
    tick();
    chk("mid_rst_drCh", int'(drCh), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_chr", int'(chr), 0);
    chk("mid_rst_loop_busy", int'(busy_l), 0);
    reset = 1'b0;

    // charDone already high on entering WAIT_DONE must not advance
    auto_r = 1'b0; charDone = 1'b1;
    sync_frame(); clr_mon();
    pulse_start(5'd2);
    run_frames(3);
    chk("held_strobes", n_st, 1);
    chk("held_busy", int'(busy), 1);
    if (n_st == 1) chk("held_c0_cleared", int'(st_c[0]), 0);
    charDone = 1'b0;
    tick();
    charDone = 1'b1;
    tick();
    charDone = 1'b0;
    auto_r = 1'b1; rd_cnt = 0;
    run_frames(2);
    chk("held_strobes_after", n_st, 2);
    if (n_st == 2) chk("held_x1", int'(st_x[1]), 24);
    chk("held_done_cnt", n_done, 1);
    chk("held_busy_down", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
